// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns EX/MEM memRead/memWrite into a req/ack
// access and stalls the pipeline until done. Optional abandon-on-timeout via MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memRead_in,
    input  logic          memWrite_in,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          stall,
    output logic [DW-1:0] rdata_out,
    output logic          rdata_valid,
    output logic          timeout_err
);
    // Handshake: mem_req stays high with mem_we/mem_addr/mem_wdata frozen until the
    // cycle mem_ack is seen high; mem_ack outside REQ carries no meaning and is ignored.
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_nxt;
    logic   access_req;
    logic   ack_take;
    logic   abandon;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT must be in 1..255");
    end

    assign access_req = memRead_in | memWrite_in;
    assign ack_take   = (state == REQ) && mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Abandon on the last allowed REQ cycle; an ack in that same cycle still wins.
    assign abandon = (state == REQ) && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state != REQ)
                wait_cnt <= 8'd0;
            else if (!mem_ack)
                wait_cnt <= wait_cnt + 8'd1;
            if (abandon)
                timeout_err <= 1'b1;
        end
    end
`else
    assign abandon     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && access_req) begin
                mem_addr  <= addr_in;
                mem_wdata <= wdata_in;
                mem_we    <= memWrite_in;
            end
            if (ack_take && !mem_we)
                rdata_out <= mem_rdata;
            else if (abandon)
                rdata_out <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = access_req;
                if (access_req)
                    state_nxt = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (ack_take || abandon)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset drops the stall at once even though memRead/memWrite may still be high.
        if (rst)
            stall = 1'b0;
    end

    assign mem_req     = (state == REQ);
    assign rdata_valid = (state == DONE) && !mem_we;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, back-to-back, read+write,
// async reset mid-access and (with MEM_TIMEOUT_EN) the timeout path.
module tb_mem_access_ctrl;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memRead_in = 1'b0;
    logic          memWrite_in = 1'b0;
    logic [DW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          stall;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        memRead_in = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall, rdata_out, rdata_valid, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset_values: got req=%b we=%b addr=%h wdata=%h stall=%b rdata=%h valid=%b terr=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, stall, rdata_out, rdata_valid, timeout_err);
        end
        memRead_in = 1'b0;
        rst = 1'b0;
        next_cycle();
    endtask

    // Load at 0x0040, ack on 3rd REQ cycle: stall cycles 1-4, req 2-4, valid in cycle 5.
    task automatic test_load();
        int req_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            memRead_in = (c <= 5);
            addr_in    = 16'h0040;
            mem_ack    = (c == 4);
            mem_rdata  = (c == 4) ? 16'hBEEF : 16'h0BAD;
            @(negedge clk);
            total++;
            if (stall !== (c <= 4)) begin
                bad++; $display("FAIL load_stall c=%0d: got %b want %b", c, stall, (c <= 4));
            end
            total++;
            if (mem_req !== (c >= 2 && c <= 4)) begin
                bad++; $display("FAIL load_req c=%0d: got %b want %b", c, mem_req, (c >= 2 && c <= 4));
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                total++;
                if (mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
                    bad++; $display("FAIL load_cmd c=%0d: got we=%b addr=%h want we=0 addr=0040", c, mem_we, mem_addr);
                end
            end
            total++;
            if (rdata_valid !== (c == 5)) begin
                bad++; $display("FAIL load_valid c=%0d: got %b want %b", c, rdata_valid, (c == 5));
            end
            if (c == 5) begin
                total++;
                if (rdata_out !== 16'hBEEF) begin
                    bad++; $display("FAIL load_data: got %h want beef", rdata_out);
                end
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        total++;
        if (req_cnt != 3) begin
            bad++; $display("FAIL load_req_len: got %0d want 3", req_cnt);
        end
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL load_terr: got %b want 0", timeout_err);
        end
    endtask

    // Store 0x1234 at 0x0010, ack on 1st REQ cycle: stall 2 cycles, req 1 cycle, no valid.
    task automatic test_store();
        for (int c = 1; c <= 4; c++) begin
            memWrite_in = (c <= 3);
            addr_in     = 16'h0010;
            wdata_in    = 16'h1234;
            mem_ack     = (c == 2);
            @(negedge clk);
            total++;
            if (stall !== (c <= 2)) begin
                bad++; $display("FAIL store_stall c=%0d: got %b want %b", c, stall, (c <= 2));
            end
            total++;
            if (mem_req !== (c == 2)) begin
                bad++; $display("FAIL store_req c=%0d: got %b want %b", c, mem_req, (c == 2));
            end
            if (c == 2) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
                    bad++; $display("FAIL store_cmd: got we=%b addr=%h wdata=%h want we=1 addr=0010 wdata=1234",
                                    mem_we, mem_addr, mem_wdata);
                end
            end
            total++;
            if (rdata_valid !== 1'b0) begin
                bad++; $display("FAIL store_valid c=%0d: got %b want 0", c, rdata_valid);
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        total++;
        if (rdata_out !== 16'hBEEF) begin
            bad++; $display("FAIL store_rdata_hold: got %h want beef", rdata_out);
        end
    endtask

    // Loads at 0x0002 then 0x0004 with immediate acks: requests in cycles 2 and 5.
    task automatic test_back_to_back();
        int req_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            memRead_in = (c <= 6);
            addr_in    = (c <= 3) ? 16'h0002 : 16'h0004;
            mem_ack    = (c == 2 || c == 5);
            mem_rdata  = (c == 2) ? 16'h1111 : ((c == 5) ? 16'h2222 : 16'hDEAD);
            @(negedge clk);
            total++;
            if (mem_req !== (c == 2 || c == 5)) begin
                bad++; $display("FAIL b2b_req c=%0d: got %b want %b", c, mem_req, (c == 2 || c == 5));
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                total++;
                if (mem_addr !== ((c == 2) ? 16'h0002 : 16'h0004)) begin
                    bad++; $display("FAIL b2b_addr c=%0d: got %h", c, mem_addr);
                end
            end
            total++;
            if (stall !== (c == 1 || c == 2 || c == 4 || c == 5)) begin
                bad++; $display("FAIL b2b_stall c=%0d: got %b", c, stall);
            end
            total++;
            if (rdata_valid !== (c == 3 || c == 6)) begin
                bad++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, rdata_valid, (c == 3 || c == 6));
            end
            if (c == 3 || c == 6) begin
                total++;
                if (rdata_out !== ((c == 3) ? 16'h1111 : 16'h2222)) begin
                    bad++; $display("FAIL b2b_data c=%0d: got %h", c, rdata_out);
                end
            end
            next_cycle();
        end
        mem_ack = 1'b0;
        total++;
        if (req_cnt != 2) begin
            bad++; $display("FAIL b2b_req_count: got %0d want 2", req_cnt);
        end
    endtask

    // Read and write together at 0x00FF: one write transaction, no load data.
    task automatic test_read_write_both();
        for (int c = 1; c <= 4; c++) begin
            memRead_in  = (c <= 3);
            memWrite_in = (c <= 3);
            addr_in     = 16'h00FF;
            wdata_in    = 16'hA5A5;
            mem_ack     = (c == 2);
            mem_rdata   = 16'h5555;
            @(negedge clk);
            total++;
            if (mem_req !== (c == 2)) begin
                bad++; $display("FAIL both_req c=%0d: got %b want %b", c, mem_req, (c == 2));
            end
            if (c == 2) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h00FF || mem_wdata !== 16'hA5A5) begin
                    bad++; $display("FAIL both_cmd: got we=%b addr=%h wdata=%h want we=1 addr=00ff wdata=a5a5",
                                    mem_we, mem_addr, mem_wdata);
                end
            end
            total++;
            if (rdata_valid !== 1'b0) begin
                bad++; $display("FAIL both_valid c=%0d: got %b want 0", c, rdata_valid);
            end
            next_cycle();
        end
        memRead_in = 1'b0; memWrite_in = 1'b0; mem_ack = 1'b0;
        total++;
        if (rdata_out !== 16'h2222) begin
            bad++; $display("FAIL both_rdata_hold: got %h want 2222", rdata_out);
        end
    endtask

    // Reset in the middle of a REQ cycle, then a normal load afterwards.
    task automatic test_async_reset();
        memRead_in = 1'b1;
        addr_in    = 16'h0030;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || stall !== 1'b1) begin
            bad++; $display("FAIL arst_pre: got req=%b stall=%b want 1 1", mem_req, stall);
        end
        #2;
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h9999;
        #1;
        total++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL arst_immediate: got req=%b stall=%b want 0 0", mem_req, stall);
        end
        total++;
        if ({mem_we, mem_addr, mem_wdata, rdata_out, rdata_valid, timeout_err} !== '0) begin
            bad++; $display("FAIL arst_values: got we=%b addr=%h wdata=%h rdata=%h valid=%b terr=%b",
                            mem_we, mem_addr, mem_wdata, rdata_out, rdata_valid, timeout_err);
        end
        memRead_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            memRead_in = (c <= 3);
            addr_in    = 16'h0050;
            mem_ack    = (c == 2);
            mem_rdata  = (c == 2) ? 16'h7777 : 16'h0BAD;
            @(negedge clk);
            total++;
            if (mem_req !== (c == 2) || stall !== (c <= 2)) begin
                bad++; $display("FAIL arst_after c=%0d: got req=%b stall=%b", c, mem_req, stall);
            end
            total++;
            if (rdata_valid !== (c == 3) || (c == 3 && rdata_out !== 16'h7777)) begin
                bad++; $display("FAIL arst_after_data c=%0d: got valid=%b rdata=%h", c, rdata_valid, rdata_out);
            end
            next_cycle();
        end
        mem_ack = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    // TIMEOUT=4 load without ack: req for 4 cycles, then DONE with zero data and sticky error.
    task automatic test_timeout();
        for (int c = 1; c <= 7; c++) begin
            memRead_in = (c <= 6);
            addr_in    = 16'h0060;
            mem_ack    = 1'b0;
            @(negedge clk);
            total++;
            if (mem_req !== (c >= 2 && c <= 5)) begin
                bad++; $display("FAIL to_req c=%0d: got %b want %b", c, mem_req, (c >= 2 && c <= 5));
            end
            total++;
            if (rdata_valid !== (c == 6) || timeout_err !== (c >= 6)) begin
                bad++; $display("FAIL to_flags c=%0d: got valid=%b terr=%b", c, rdata_valid, timeout_err);
            end
            if (c == 6) begin
                total++;
                if (rdata_out !== 16'h0000) begin
                    bad++; $display("FAIL to_data: got %h want 0000", rdata_out);
                end
            end
            next_cycle();
        end
        for (int c = 1; c <= 4; c++) begin
            memWrite_in = (c <= 3);
            mem_ack     = (c == 2);
            next_cycle();
        end
        memWrite_in = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_sticky: got %b want 1", timeout_err);
        end
        rst = 1'b1;
        #1;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL to_clear: got %b want 0", timeout_err);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_read_write_both();
        test_async_reset();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory access performed in the MEM stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and a variable-latency data memory. It converts the registered memRead/memWrite controls into a req/ack transaction and stalls the upstream pipeline until the access completes. It delivers load data, with a one-cycle valid pulse, toward the MEM/WB register.

## Interface
- DW, 16, data and address width (matches `DSIZE)
- TIMEOUT, 15, max REQ cycles waiting for ack (used only with MEM_TIMEOUT_EN); legal 1..255
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- memRead_in  in  1  load request from EX/MEM register
- memWrite_in  in  1  store request from EX/MEM register
- addr_in  in  DW  ALU result (byte-agnostic word address) from EX/MEM
- wdata_in  in  DW  store data (Rdata2) from EX/MEM
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  DW  load data, sampled on the mem_ack cycle
- mem_req  out  1  access request, held until ack
- mem_we  out  1  1=write, 0=read; stable while mem_req=1
- mem_addr  out  DW  access address; stable while mem_req=1
- mem_wdata  out  DW  store data; stable while mem_req=1
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM registers
- rdata_out  out  DW  captured load data
- rdata_valid  out  1  one-cycle pulse: rdata_out valid for writeback
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, DONE. Reset state IDLE.
- IDLE: if memWrite_in|memRead_in, then stall=1 (combinational), latch addr_in→mem_addr, wdata_in→mem_wdata, memWrite_in→mem_we, then go REQ. Otherwise stall=0 and stay.
- Both memRead_in and memWrite_in set: treated as a store (mem_we=1). No rdata_valid.
- REQ: mem_req=1, stall=1. On mem_ack: if mem_we=0, capture mem_rdata→rdata_out; go DONE. Without ack: stay.
- DONE: stall=0, so EX/MEM advances this cycle. rdata_valid=1 iff the completed access was a load. Unconditionally go IDLE (the next instruction is evaluated in IDLE next cycle; no re-issue of the finished access).
- mem_ack in IDLE/DONE: ignored.
- rdata_out holds its value until the next load completes.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, rdata_out=0, rdata_valid=0, timeout_err=0.

## Timing
- mem_req, mem_we, mem_addr, mem_wdata, rdata_out, rdata_valid: registered/state-decoded, no combinational path from inputs.
- stall: Mealy in IDLE (from memRead_in|memWrite_in), Moore elsewhere.
- Access with ack on the Nth REQ cycle (N≥1):
  - stall high for N+1 cycles (detect cycle plus N REQ cycles).
  - rdata_valid on cycle N+2.
  - Minimum total: 3 cycles per access.
- Back-to-back accesses: the next access is detected in the cycle after DONE. There is no bubble beyond the DONE cycle.
- Async rst mid-REQ: mem_req and stall drop immediately (not at the next edge). The in-flight ack is discarded and the FSM restarts in IDLE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on IDLE→REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT, the access is abandoned: mem_req drops, go DONE, rdata_out=0, rdata_valid=1 if a load, timeout_err=1.
  - timeout_err is sticky until rst.
  - An ack on the same cycle as the counter reaching TIMEOUT wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; timeout_err is tied 0.

## Test plan
- Load, addr 0x0040, ack on 3rd REQ cycle with mem_rdata=0xBEEF → mem_req high 3 cycles with mem_we=0, mem_addr=0x0040; stall high 4 cycles; rdata_valid pulse with rdata_out=0xBEEF in the 5th cycle.
- Store, addr 0x0010, data 0x1234, ack in 1st REQ cycle → mem_we=1, mem_wdata=0x1234 for 1 cycle; stall 2 cycles; rdata_valid stays 0.
- Two consecutive loads (0x0002 then 0x0004, ack immediate) → two distinct req transactions 3 cycles apart; rdata_valid twice with the correct data; no duplicate request.
- memRead_in=memWrite_in=1, addr 0x00FF → single write transaction (mem_we=1); rdata_valid=0.
- rst asserted mid-REQ (between edges) → mem_req=0 and stall=0 immediately; all outputs at reset values; first access after rst behaves normally.
- MEM_TIMEOUT_EN, TIMEOUT=4, load with no ack → mem_req high exactly 4 cycles, then DONE with rdata_out=0, rdata_valid=1, timeout_err=1 and held through later accesses until rst.
